// File: rtl/usart_rx.sv
// usart_rx: 8N1 UART receiver with 16x oversampling and a single holding register.
// Define USART_RX_PARITY_EN to add a parity bit between data and stop (sense from PARITY_ODD).
module usart_rx #(
  parameter int OVERSAMPLE_DIV = 104,
  parameter int PARITY_ODD     = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_pin,
  input  logic       read,
  input  logic       clear_errors,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       framing_error,
  output logic       parity_error,
  output logic       overrun_error,
  output logic       busy
);

  localparam logic [15:0] DIV_MAX = 16'(OVERSAMPLE_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef USART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t      state, state_next;
  logic        rx_meta, rxs;
  logic [15:0] div_cnt;
  logic        tick;
  logic [3:0]  scnt, scnt_next;
  logic [2:0]  bit_idx, bit_next;
  logic [7:0]  shift, shift_next;
  logic        s7, s7_next, s8, s8_next;
  logic        maj;
  logic        done, done_next;
  logic        stop_bit, stop_next;
  logic        par_err;

  // Synchronizer resets to the idle (high) line level so a reset never fakes a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      div_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      rx_meta <= rx_pin;
      rxs     <= rx_meta;
      div_cnt <= tick ? '0 : div_cnt + 16'd1;
    end
  end

  assign tick = (div_cnt == DIV_MAX);
  assign maj  = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
  assign busy = (state != IDLE);

`ifdef USART_RX_PARITY_EN
  logic par_bit, par_next;

  always_ff @(posedge clk) begin
    if (reset) par_bit <= 1'b0;
    else       par_bit <= par_next;
  end

  assign par_err = ((^shift) ^ par_bit) != PARITY_ODD[0];
`else
  assign par_err = PARITY_ODD[0] & 1'b0;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_next = state;
    scnt_next  = scnt;
    bit_next   = bit_idx;
    shift_next = shift;
    s7_next    = s7;
    s8_next    = s8;
    done_next  = 1'b0;
    stop_next  = stop_bit;
`ifdef USART_RX_PARITY_EN
    par_next   = par_bit;
`endif
    if (tick) begin
      scnt_next = scnt + 4'd1;
      if (scnt == 4'd7) s7_next = rxs;
      if (scnt == 4'd8) s8_next = rxs;
      unique case (state)
        IDLE: begin
          scnt_next = 4'd0;
          if (!rxs) state_next = START;
        end
        START: begin
          if (scnt == 4'd9 && maj) begin
            state_next = IDLE;
            scnt_next  = 4'd0;
          end else if (scnt == 4'd15) begin
            state_next = DATA;
            bit_next   = 3'd0;
          end
        end
        DATA: begin
          // Line order is LSB first, so shifting in at the MSB leaves bit 0 at the bottom.
          if (scnt == 4'd9) shift_next = {maj, shift[7:1]};
          if (scnt == 4'd15) begin
            if (bit_idx == 3'd7) begin
`ifdef USART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              bit_next = bit_idx + 3'd1;
            end
          end
        end
`ifdef USART_RX_PARITY_EN
        PARITY: begin
          if (scnt == 4'd9) par_next = maj;
          if (scnt == 4'd15) state_next = STOP;
        end
`endif
        STOP: begin
          // Leave at mid-stop so a back-to-back start edge is still caught.
          if (scnt == 4'd9) begin
            stop_next  = maj;
            done_next  = 1'b1;
            state_next = IDLE;
            scnt_next  = 4'd0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      scnt     <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      s7       <= 1'b1;
      s8       <= 1'b1;
      done     <= 1'b0;
      stop_bit <= 1'b1;
    end else begin
      state    <= state_next;
      scnt     <= scnt_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      s7       <= s7_next;
      s8       <= s8_next;
      done     <= done_next;
      stop_bit <= stop_next;
    end
  end

  // Holding register: a read in the completion clk frees the slot for the new byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out      <= '0;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      parity_error  <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      if (clear_errors) overrun_error <= 1'b0;
      if (done) begin
        if (!data_ready || read) begin
          data_out      <= shift;
          framing_error <= ~stop_bit;
          parity_error  <= par_err;
          data_ready    <= 1'b1;
        end else begin
          overrun_error <= 1'b1;
        end
      end else if (read) begin
        data_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_usart_rx.sv
// Self-checking bench for usart_rx: directed scenarios plus randomized frames against a holding-register model.
module tb_usart_rx;

  localparam int DIV      = 4;
  localparam int BIT_CLKS = DIV * 16;
  localparam int P_ODD    = 0;

  logic       clk = 1'b0;
  logic       reset, rx_pin, read, clear_errors;
  logic [7:0] data_out;
  logic       data_ready, framing_error, parity_error, overrun_error, busy;

  int checks = 0;
  int errors = 0;

  // Model of the bus-visible holding register.
  logic [7:0] m_data;
  logic       m_ready, m_fe, m_pe, m_ovr;

  usart_rx #(.OVERSAMPLE_DIV(DIV), .PARITY_ODD(P_ODD)) dut (
    .clk(clk), .reset(reset), .rx_pin(rx_pin), .read(read), .clear_errors(clear_errors),
    .data_out(data_out), .data_ready(data_ready), .framing_error(framing_error),
    .parity_error(parity_error), .overrun_error(overrun_error), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_data = '0; m_ready = 0; m_fe = 0; m_pe = 0; m_ovr = 0;
  endtask

  task automatic model_complete(input logic [7:0] d, input logic stop_v, input logic par_v,
                                input logic rd);
    if (!m_ready || rd) begin
      m_data  = d;
      m_fe    = ~stop_v;
`ifdef USART_RX_PARITY_EN
      m_pe    = (((^d) ^ par_v) != P_ODD[0]);
`else
      m_pe    = 1'b0 & par_v;
`endif
      m_ready = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic strobe_read();
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic strobe_clear();
    clear_errors = 1'b1;
    @(negedge clk);
    clear_errors = 1'b0;
    m_ovr = 1'b0;
  endtask

  // Drives one frame; during the stop bit watches busy fall (stop-sample tick) and can
  // raise read for exactly the following clk, which is the completion clk.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v,
                            input logic rd_at_done, output logic seen);
    seen = 1'b0;
    rx_pin = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      wait_clks(BIT_CLKS);
    end
`ifdef USART_RX_PARITY_EN
    rx_pin = par_v;
    wait_clks(BIT_CLKS);
`endif
    rx_pin = stop_v;
    for (int k = 0; k < BIT_CLKS; k++) begin
      @(negedge clk);
      read = 1'b0;
      if (!seen && !busy) begin
        seen = 1'b1;
        read = rd_at_done;
      end
    end
    read = 1'b0;
    rx_pin = 1'b1;
  endtask

  task automatic frame(input logic [7:0] d, input logic stop_v, input logic par_v,
                       input logic rd_at_done);
    logic seen;
    send_frame(d, stop_v, par_v, rd_at_done, seen);
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: busy never fell during stop bit of byte %h", d);
    end
    model_complete(d, stop_v, par_v, rd_at_done);
    wait_clks(2 * BIT_CLKS);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_clks(3);
    checks++;
    if ({data_out, data_ready, framing_error, parity_error, overrun_error, busy} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {data_out, data_ready, framing_error, parity_error, overrun_error, busy});
    end
    reset = 1'b0;
    model_reset();
    wait_clks(2 * BIT_CLKS);
    checks++;
    if (busy !== 1'b0 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy %b ready %b required 0 0", busy, data_ready);
    end
  endtask

  task automatic test_basic();
    frame(8'h55, 1'b1, 1'b0, 1'b0);
    checks++;
    if (data_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b required 1", data_ready); end
    checks++;
    if (data_out !== 8'h55) begin errors++; $display("FAIL basic_data: got %h required 55", data_out); end
    checks++;
    if (framing_error !== 1'b0 || parity_error !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags: fe %b pe %b required 0 0", framing_error, parity_error);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b required 0", busy); end
    strobe_read();
    checks++;
    if (data_ready !== 1'b0) begin errors++; $display("FAIL read_clears: got %b required 0", data_ready); end
    checks++;
    if (data_out !== 8'h55) begin errors++; $display("FAIL read_holds_data: got %h required 55", data_out); end
    read = 1'b1;  // read with nothing held must have no effect
    @(negedge clk);
    read = 1'b0;
    checks++;
    if (data_ready !== 1'b0 || data_out !== 8'h55) begin
      errors++;
      $display("FAIL idle_read: ready %b data %h required 0 55", data_ready, data_out);
    end
  endtask

  task automatic test_glitch();
    rx_pin = 1'b0;
    wait_clks(3 * DIV);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise: got %b required 1", busy); end
    wait_clks(2 * DIV);
    rx_pin = 1'b1;
    wait_clks(10 * DIV);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_fall: got %b required 0", busy); end
    wait_clks(2 * BIT_CLKS);
    checks++;
    if (data_ready !== 1'b0 || overrun_error !== 1'b0) begin
      errors++;
      $display("FAIL glitch_no_byte: ready %b ovr %b required 0 0", data_ready, overrun_error);
    end
  endtask

  task automatic test_framing();
    frame(8'hA3, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({data_ready, data_out, framing_error} !== {1'b1, 8'hA3, 1'b1}) begin
      errors++;
      $display("FAIL framing_bad_stop: ready %b data %h fe %b required 1 a3 1",
               data_ready, data_out, framing_error);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL framing_resync: busy %b required 0", busy); end
    strobe_read();
    frame(8'h0F, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({data_ready, data_out, framing_error} !== {1'b1, 8'h0F, 1'b0}) begin
      errors++;
      $display("FAIL framing_clean: ready %b data %h fe %b required 1 0f 0",
               data_ready, data_out, framing_error);
    end
  endtask

  task automatic test_overrun();
    strobe_read();
    frame(8'h11, 1'b1, 1'b0, 1'b0);
    frame(8'h22, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({data_ready, data_out, overrun_error} !== {1'b1, 8'h11, 1'b1}) begin
      errors++;
      $display("FAIL overrun_set: ready %b data %h ovr %b required 1 11 1",
               data_ready, data_out, overrun_error);
    end
    strobe_clear();
    checks++;
    if (overrun_error !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b required 0", overrun_error); end
    frame(8'h22, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({data_ready, data_out, overrun_error} !== {1'b1, 8'h22, 1'b0}) begin
      errors++;
      $display("FAIL read_on_completion: ready %b data %h ovr %b required 1 22 0",
               data_ready, data_out, overrun_error);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    logic       seen;
    d = 8'h5A;
    rx_pin = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rx_pin = d[i];
      wait_clks(BIT_CLKS);
    end
    rx_pin = d[4];
    wait_clks(BIT_CLKS / 2);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_frame_busy: got %b required 1", busy); end
    reset = 1'b1;
    wait_clks(2);
    checks++;
    if ({data_out, data_ready, framing_error, parity_error, overrun_error, busy} !== 13'd0) begin
      errors++;
      $display("FAIL mid_frame_reset: got %h required 0",
               {data_out, data_ready, framing_error, parity_error, overrun_error, busy});
    end
    reset = 1'b0;
    rx_pin = 1'b1;
    model_reset();
    wait_clks(2 * BIT_CLKS);
    send_frame(8'hC7, 1'b1, ^8'hC7, 1'b0, seen);
    model_complete(8'hC7, 1'b1, ^8'hC7, 1'b0);
    wait_clks(2 * BIT_CLKS);
    checks++;
    if ({seen, data_ready, data_out, framing_error, parity_error, overrun_error} !==
        {1'b1, 1'b1, 8'hC7, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL after_reset_byte: seen %b ready %b data %h fe %b pe %b ovr %b required 1 1 c7 0 0 0",
               seen, data_ready, data_out, framing_error, parity_error, overrun_error);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       stop_v, par_v, rd;
    int         mode;
    for (int n = 0; n < 12; n++) begin
      d      = 8'($urandom);
      stop_v = ($urandom_range(0, 3) != 0);
      par_v  = 1'($urandom);
      mode   = $urandom_range(0, 3);
      rd     = (mode == 2);
      if (mode == 1) strobe_read();
      if ($urandom_range(0, 2) == 0) strobe_clear();
      frame(d, stop_v, par_v, rd);
      checks++;
      if (data_ready !== m_ready) begin
        errors++; $display("FAIL rand%0d_ready: got %b required %b", n, data_ready, m_ready);
      end
      checks++;
      if (data_out !== m_data) begin
        errors++; $display("FAIL rand%0d_data: got %h required %h", n, data_out, m_data);
      end
      checks++;
      if ({framing_error, parity_error, overrun_error} !== {m_fe, m_pe, m_ovr}) begin
        errors++;
        $display("FAIL rand%0d_flags: fe/pe/ovr got %b%b%b required %b%b%b", n,
                 framing_error, parity_error, overrun_error, m_fe, m_pe, m_ovr);
      end
    end
  endtask

`ifdef USART_RX_PARITY_EN
  task automatic test_parity();
    strobe_read();
    frame(8'h07, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({data_ready, data_out, parity_error} !== {1'b1, 8'h07, 1'b0}) begin
      errors++;
      $display("FAIL parity_good: ready %b data %h pe %b required 1 07 0", data_ready, data_out, parity_error);
    end
    strobe_read();
    frame(8'h07, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({data_ready, data_out, parity_error} !== {1'b1, 8'h07, 1'b1}) begin
      errors++;
      $display("FAIL parity_bad: ready %b data %h pe %b required 1 07 1", data_ready, data_out, parity_error);
    end
  endtask
`endif

  initial begin
    reset        = 1'b1;
    rx_pin       = 1'b1;
    read         = 1'b0;
    clear_errors = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_mid_frame();
`ifdef USART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
